// File: rtl/linked_fifo_drain.sv
// Round-robin read engine for the multi-queue linked_fifo; streams tagged words downstream.
// Define LINKED_FIFO_DRAIN_STATS_EN to add per-queue saturating pop counters.
module linked_fifo_drain #(
    parameter int unsigned QUEUES     = 8,
    parameter int unsigned QW         = 3,
    parameter int unsigned DW         = 8,
    parameter int unsigned CW         = 3,
    parameter int unsigned LAT        = 1,
    parameter int unsigned OBUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [QUEUES-1:0]    queue_en,
    input  logic [QUEUES*CW-1:0] fifo_count,
    output logic                 fifo_pop,
    output logic [QW-1:0]        fifo_pop_fifo,
    input  logic [DW-1:0]        fifo_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [QW-1:0]        out_queue,
    output logic                 busy
`ifdef LINKED_FIFO_DRAIN_STATS_EN
    ,
    input  logic [QW-1:0]        stat_sel,
    output logic [15:0]          stat_pops
`endif
);
    localparam int unsigned AW   = $clog2(OBUF_DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [QUEUES-1:0] elig;
    logic              grant_found;
    logic [QW-1:0]     grant_id;
    logic [QW-1:0]     ptr_q;
    logic [QW-1:0]     last_id_q;
    logic [LAT-1:0]    pv_q;
    logic [QW-1:0]     pid_q    [LAT];
    logic [DW-1:0]     mem_data [OBUF_DEPTH];
    logic [QW-1:0]     mem_id   [OBUF_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]   occ_q, occ_d, inflight, credit;
    logic              wr_en, rd_en;

    always_comb begin
        elig = '0;
        for (int i = 0; i < QUEUES; i++) begin
            elig[i] = queue_en[i] && (fifo_count[i*CW +: CW] != '0);
        end
    end

    // First eligible queue at or after the pointer; QUEUES is a power of 2 so the sum wraps.
    always_comb begin
        logic [QW-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < QUEUES; k++) begin
            idx = ptr_q + QW'(k);
            if (!grant_found && elig[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Every in-flight pop owns a buffer slot, so a full buffer is never written.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CNTW'(pv_q[i]);
        end
        credit = CNTW'(OBUF_DEPTH) - occ_q - inflight;
    end

    assign fifo_pop      = grant_found && (credit != '0);
    assign fifo_pop_fifo = fifo_pop ? grant_id : last_id_q;

    assign wr_en     = pv_q[LAT-1];
    assign out_valid = (occ_q != '0);
    assign rd_en     = out_valid && out_ready;
    assign occ_d     = occ_q + CNTW'(wr_en) - CNTW'(rd_en);
    assign out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_queue = out_valid ? mem_id[rd_ptr_q] : '0;
    assign busy      = (pv_q != '0) || out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            last_id_q <= '0;
            pv_q      <= '0;
            for (int i = 0; i < LAT; i++) begin
                pid_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            if (fifo_pop) begin
                ptr_q     <= grant_id + QW'(1);
                last_id_q <= grant_id;
            end
            pv_q[0]  <= fifo_pop;
            pid_q[0] <= fifo_pop_fifo;
            for (int i = 1; i < LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pid_q[i] <= pid_q[i-1];
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            occ_q <= occ_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= fifo_q;
            mem_id[wr_ptr_q]   <= pid_q[LAT-1];
        end
    end

`ifdef LINKED_FIFO_DRAIN_STATS_EN
    logic [15:0] stat_q [QUEUES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUES; i++) begin
                stat_q[i] <= '0;
            end
        end else if (fifo_pop && (stat_q[grant_id] != 16'hFFFF)) begin
            stat_q[grant_id] <= stat_q[grant_id] + 16'd1;
        end
    end

    assign stat_pops = stat_q[stat_sel];
`endif

endmodule
